// File: rtl/traffic_ctrl_timed_pkg.sv
// Shared types and constants for the timed intersection controller:
// FSM state codes (also exported as the debug state code) and lamp encodings.
package traffic_ctrl_timed_pkg;

  typedef enum logic [2:0] {
    HWY_GREEN  = 3'd0,
    HWY_YEL    = 3'd1,
    ALLRED_H   = 3'd2,
    CTRY_GREEN = 3'd3,
    CTRY_YEL   = 3'd4,
    ALLRED_C   = 3'd5,
    DISABLED   = 3'd6
  } state_t;

  // Lamp vector layout is {red, yellow, green}.
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  function automatic logic is_yellow(input state_t s);
    return (s == HWY_YEL) || (s == CTRY_YEL);
  endfunction

endpackage

// File: rtl/traffic_ctrl_timed_if.sv
// Sensor/prescaler inputs and lamp-driver outputs of the intersection controller.
// master: the environment (sensors, prescaler, lamp drivers); slave: the controller.
interface traffic_ctrl_timed_if;

  logic       sys_en;
  logic       tick;
  logic       vehicle;
  logic       snow;
  logic [2:0] hwy_light;
  logic [2:0] ctry_light;
  logic [2:0] state_o;

  modport master (
    output sys_en, tick, vehicle, snow,
    input  hwy_light, ctry_light, state_o
  );

  modport slave (
    input  sys_en, tick, vehicle, snow,
    output hwy_light, ctry_light, state_o
  );

endinterface

// File: rtl/traffic_ctrl_timed_phase_timer.sv
// Phase elapsed-time counter: counts ticks since the current phase began,
// saturating at all-ones; clear wins over tick.
module traffic_ctrl_timed_phase_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             tick_i,
  output logic [CNT_W-1:0] elapsed_o
);

  localparam logic [CNT_W-1:0] SAT = '1;

  logic [CNT_W-1:0] elapsed_q, elapsed_d;

  // Next count: clear, saturating increment on tick, or hold.
  always_comb begin
    // NOTE: assigning the default first means every path drives elapsed_d, so no latch is inferred.
    elapsed_d = elapsed_q;
    if (clear_i) begin
      elapsed_d = '0;
    end else if (tick_i && (elapsed_q != SAT)) begin
      elapsed_d = elapsed_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of block order.
    if (reset) elapsed_q <= '0;
    else       elapsed_q <= elapsed_d;
  end

  assign elapsed_o = elapsed_q;

endmodule

// File: rtl/traffic_ctrl_timed.sv
// Timed highway/country-road intersection controller with yellow and all-red
// clearance phases, min/max greens, snow-extended yellow and a disabled mode.
// Optional build macro TRAFFIC_FLASH_EN: flash the lamps while DISABLED
// (highway yellow, country red); otherwise DISABLED is steady red on both roads.
module traffic_ctrl_timed
  import traffic_ctrl_timed_pkg::*;
#(
  parameter int CNT_W       = 6,
  parameter int HWY_MIN     = 8,
  parameter int CTRY_MIN    = 2,
  parameter int CTRY_MAX    = 6,
  parameter int YEL_T       = 3,
  parameter int SNOW_YEL_T  = 5,
  parameter int ALLRED_T    = 1,
  parameter int FLASH_TICKS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  traffic_ctrl_timed_if.slave  bus
);

  localparam int LIM = 1 << CNT_W;

  if (HWY_MIN < 1 || CTRY_MIN < 1 || CTRY_MAX < 1 || YEL_T < 1 || SNOW_YEL_T < 1 ||
      ALLRED_T < 1 || FLASH_TICKS < 1 || CTRY_MIN > CTRY_MAX ||
      HWY_MIN >= LIM || CTRY_MAX >= LIM || YEL_T >= LIM || SNOW_YEL_T >= LIM ||
      ALLRED_T >= LIM || FLASH_TICKS >= LIM) begin : g_bad_params
    $error("traffic_ctrl_timed: illegal timing parameters");
  end

  localparam logic [CNT_W-1:0] HWY_MIN_L  = CNT_W'(HWY_MIN);
  localparam logic [CNT_W-1:0] CTRY_MIN_L = CNT_W'(CTRY_MIN);
  localparam logic [CNT_W-1:0] CTRY_MAX_L = CNT_W'(CTRY_MAX);
  localparam logic [CNT_W-1:0] YEL_L      = CNT_W'(YEL_T);
  localparam logic [CNT_W-1:0] SNOW_YEL_L = CNT_W'(SNOW_YEL_T);
  localparam logic [CNT_W-1:0] ALLRED_L   = CNT_W'(ALLRED_T);

  state_t           state_q, state_d;
  logic             entry_q;      // first cycle spent in the current state
  logic [CNT_W-1:0] elapsed;
  logic [CNT_W-1:0] yel_len_q;
  logic [CNT_W-1:0] yel_fresh;
  logic [CNT_W-1:0] yel_len;
  logic             timer_clear;
  logic [2:0]       hwy_lamp, ctry_lamp;

  // On the tick that completes a phase of len ticks the counter reads len-1.
  function automatic logic reached(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] len);
    return cnt >= (len - CNT_W'(1));
  endfunction

  // Snow is sampled during the first cycle of a yellow; that sample already governs that cycle.
  assign yel_fresh   = bus.snow ? SNOW_YEL_L : YEL_L;
  assign yel_len     = (entry_q && is_yellow(state_q)) ? yel_fresh : yel_len_q;
  assign timer_clear = (state_d != state_q) || !bus.sys_en;

  traffic_ctrl_timed_phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (timer_clear),
    .tick_i    (bus.tick),
    .elapsed_o (elapsed)
  );

  // State register plus first-cycle-in-state flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ALLRED_C;
      entry_q <= 1'b1;
    end else begin
      state_q <= state_d;
      entry_q <= (state_d != state_q);
    end
  end

  // Yellow length latched at yellow entry, so later snow changes do not stretch it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               yel_len_q <= YEL_L;
    else if (entry_q && is_yellow(state_q)) yel_len_q <= yel_fresh;
  end

  // Next state: sys_en low overrides everything; timed exits only on a tick.
  always_comb begin
    state_d = state_q;
    if (!bus.sys_en) begin
      state_d = DISABLED;
    end else if (state_q == DISABLED) begin
      state_d = ALLRED_C;
    end else if (bus.tick) begin
      case (state_q)
        HWY_GREEN:  if (reached(elapsed, HWY_MIN_L) && bus.vehicle) state_d = HWY_YEL;
        HWY_YEL:    if (reached(elapsed, yel_len))                  state_d = ALLRED_H;
        ALLRED_H:   if (reached(elapsed, ALLRED_L))                 state_d = CTRY_GREEN;
        CTRY_GREEN: if (reached(elapsed, CTRY_MAX_L) ||
                        (reached(elapsed, CTRY_MIN_L) && !bus.vehicle)) state_d = CTRY_YEL;
        CTRY_YEL:   if (reached(elapsed, yel_len))                  state_d = ALLRED_C;
        ALLRED_C:   if (reached(elapsed, ALLRED_L))                 state_d = HWY_GREEN;
        default:    state_d = ALLRED_C;
      endcase
    end
  end

`ifdef TRAFFIC_FLASH_EN
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_TICKS - 1);

  logic [CNT_W-1:0] flash_cnt_q;
  logic             flash_on_q;

  // Blink phase: restarts "on" at every DISABLED entry and toggles every FLASH_TICKS ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b1;
    end else if (state_q != DISABLED) begin
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b1;
    end else if (bus.tick) begin
      if (flash_cnt_q == FLASH_LAST) begin
        flash_cnt_q <= '0;
        flash_on_q  <= ~flash_on_q;
      end else begin
        flash_cnt_q <= flash_cnt_q + CNT_W'(1);
      end
    end
  end
`endif

  // Moore lamp decode: red unless the state lights something else.
  always_comb begin
    hwy_lamp  = LAMP_R;
    ctry_lamp = LAMP_R;
    case (state_q)
      HWY_GREEN:  hwy_lamp  = LAMP_G;
      HWY_YEL:    hwy_lamp  = LAMP_Y;
      CTRY_GREEN: ctry_lamp = LAMP_G;
      CTRY_YEL:   ctry_lamp = LAMP_Y;
`ifdef TRAFFIC_FLASH_EN
      DISABLED: begin
        hwy_lamp  = flash_on_q ? LAMP_Y : LAMP_OFF;
        ctry_lamp = flash_on_q ? LAMP_R : LAMP_OFF;
      end
`endif
      default: ;
    endcase
  end

  assign bus.hwy_light  = hwy_lamp;
  assign bus.ctry_light = ctry_lamp;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_traffic_ctrl_timed.sv
// Scoreboard bench for traffic_ctrl_timed (default parameters). The stimulus
// process runs a phase/tick-count reference model and queues the expected
// state and lamps for every cycle; a monitor compares them on the falling edge.
module tb_traffic_ctrl_timed;
  import traffic_ctrl_timed_pkg::*;

  localparam int HWY_MIN     = 8;
  localparam int CTRY_MIN    = 2;
  localparam int CTRY_MAX    = 6;
  localparam int YEL_T       = 3;
  localparam int SNOW_YEL_T  = 5;
  localparam int ALLRED_T    = 1;
  localparam int FLASH_TICKS = 4;

  logic clk = 1'b0;
  logic reset;

  traffic_ctrl_timed_if bus ();

  traffic_ctrl_timed dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [8:0] obs;   // {state, hwy, ctry}
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: current phase, ticks spent in it, latched yellow length.
  state_t m_st;
  int     m_ticks;
  int     m_ylen;
  bit     m_first;
  int     m_cyc;
`ifdef TRAFFIC_FLASH_EN
  int     m_fticks;
`endif

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got state=%0d hwy=%b ctry=%b, want state=%0d hwy=%b ctry=%b",
               name, act[8:6], act[5:3], act[2:0], exp[8:6], exp[5:3], exp[2:0]);
    end
  endtask

  function automatic logic [5:0] lamps_now();
    case (m_st)
      HWY_GREEN:  return {LAMP_G, LAMP_R};
      HWY_YEL:    return {LAMP_Y, LAMP_R};
      CTRY_GREEN: return {LAMP_R, LAMP_G};
      CTRY_YEL:   return {LAMP_R, LAMP_Y};
`ifdef TRAFFIC_FLASH_EN
      DISABLED:   return ((m_fticks / FLASH_TICKS) % 2 == 0) ? {LAMP_Y, LAMP_R} : {LAMP_OFF, LAMP_OFF};
`endif
      default:    return {LAMP_R, LAMP_R};
    endcase
  endfunction

  function automatic void model_reset();
    m_st    = ALLRED_C;
    m_ticks = 0;
    m_ylen  = YEL_T;
    m_first = 1'b1;
    m_cyc   = 0;
`ifdef TRAFFIC_FLASH_EN
    m_fticks = 0;
`endif
  endfunction

  // Advance the model by one clock given this cycle's inputs.
  function automatic void model_advance(input bit en, input bit tk, input bit veh, input bit sn);
    state_t nxt = m_st;
    int     n   = m_ticks + (tk ? 1 : 0);   // ticks completed including this one
    if ((m_st == HWY_YEL || m_st == CTRY_YEL) && m_first) m_ylen = sn ? SNOW_YEL_T : YEL_T;
    if (!en)                    nxt = DISABLED;
    else if (m_st == DISABLED)  nxt = ALLRED_C;
    else if (tk) begin
      case (m_st)
        HWY_GREEN:  if (n >= HWY_MIN && veh)                        nxt = HWY_YEL;
        HWY_YEL:    if (n >= m_ylen)                                nxt = ALLRED_H;
        ALLRED_H:   if (n >= ALLRED_T)                              nxt = CTRY_GREEN;
        CTRY_GREEN: if (n >= CTRY_MAX || (n >= CTRY_MIN && !veh))   nxt = CTRY_YEL;
        CTRY_YEL:   if (n >= m_ylen)                                nxt = ALLRED_C;
        ALLRED_C:   if (n >= ALLRED_T)                              nxt = HWY_GREEN;
        default:    nxt = ALLRED_C;
      endcase
    end
    if (nxt != m_st) begin
      m_st    = nxt;
      m_ticks = 0;
      m_first = 1'b1;
`ifdef TRAFFIC_FLASH_EN
      m_fticks = 0;
`endif
    end else begin
      m_ticks = n;
      m_first = 1'b0;
`ifdef TRAFFIC_FLASH_EN
      if (tk && m_st == DISABLED) m_fticks++;
`endif
    end
  endfunction

  // Drive one cycle of inputs, queue the expected observation, step the model.
  task automatic step(input bit en, input bit tk, input bit veh, input bit sn);
    exp_t e;
    bus.sys_en  = en;
    bus.tick    = tk;
    bus.vehicle = veh;
    bus.snow    = sn;
    e.cyc = m_cyc;
    e.obs = {m_st, lamps_now()};
    exp_q.push_back(e);
    model_advance(en, tk, veh, sn);
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset in the middle of a cycle; its effect must be immediate.
  task automatic do_reset(input string name);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check(name, {bus.state_o, bus.hwy_light, bus.ctry_light}, {ALLRED_C, LAMP_R, LAMP_R});
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: compares every queued expectation against the DUT on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("cycle%0d", e.cyc), {bus.state_o, bus.hwy_light, bus.ctry_light}, e.obs);
      end
    end
  end

  initial begin
    bit en, veh, sn, tk;
    reset       = 1'b1;
    bus.sys_en  = 1'b1;
    bus.tick    = 1'b1;
    bus.vehicle = 1'b0;
    bus.snow    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // No traffic: highway green is held indefinitely.
    for (int c = 0; c <= 100; c++) step(1, 1, 0, 0);

    // Continuous vehicle: full cycle with country max-out.
    do_reset("reset_before_maxout");
    for (int c = 0; c < 26; c++) step(1, 1, 1, 0);

    // Vehicle leaves at cycle 15: country gap-out after min green.
    do_reset("reset_before_gapout");
    for (int c = 0; c < 24; c++) step(1, 1, c <= 14, 0);

    // Snow only on the first yellow cycle: extended yellow regardless of later drop.
    do_reset("reset_before_snow");
    for (int c = 0; c < 30; c++) step(1, 1, 1, c == 9);

    // Disable during country green, hold long enough to see flashing, re-enable.
    do_reset("reset_before_disable");
    for (int c = 0; c < 40; c++) step(!(c >= 15 && c < 30), 1, 1, 0);

    // Disable then asynchronous reset while in DISABLED.
    for (int c = 0; c < 6; c++) step(0, 1, 0, 0);
    do_reset("reset_mid_disabled");
    for (int c = 0; c < 4; c++) step(1, 1, 0, 0);

    // Randomised traffic, sparse ticks, snow and enable drops.
    en  = 1'b1;
    veh = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) veh = ~veh;
      sn = ($urandom_range(0, 3) == 0);
      tk = ($urandom_range(0, 3) != 0);
      if (en && $urandom_range(0, 79) == 0)       en = 1'b0;
      else if (!en && $urandom_range(0, 9) == 0)  en = 1'b1;
      step(en, tk, veh, sn);
      if ($urandom_range(0, 499) == 0) do_reset("reset_random");
    end

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
